float_to_fixed: RTL and testbench

Iterative half-precision-to-fixed-point converter that sits directly downstream of the fixed-to-float stage in the same program flow. It reads the packed 16-bit float the upstream stage writes to data memory and decodes sign/exponent/mantissa. It then shifts the 11-bit significand one bit per cycle and writes the 16-bit sign-magnitude integer back to data memory. It drives the byte-wide `data_mem` port as sole master and reports completion on `done`.

---
 rtl/f2i_pkg.sv | 58 +++++
 rtl/f2i_shifter.sv | 63 ++++++
 rtl/float_to_fixed.sv | 148 ++++++++++++++
 tb/tb_float_to_fixed.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/f2i_pkg.sv
// Shared types, constants and the float16 decode helper for float_to_fixed.
package f2i_pkg;

  localparam int unsigned EXP_W        = 5;
  localparam int unsigned MANT_W       = 10;
  localparam int unsigned MAG_W        = 15;
  localparam int unsigned SIG_W        = MANT_W + 1;
  localparam int unsigned WORD_W       = 16;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned F16_BIAS     = 15;
  // Exponent at which the significand LSB has weight 1.
  localparam int unsigned INT_POINT    = F16_BIAS + MANT_W;
  localparam int unsigned EXP_SAT      = 30;
  localparam int unsigned EXP_ZERO_MAX = 13;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_CAPTURE,
    S_DECODE,
    S_SHIFT,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  // Shifter load command: direction, step count and initial magnitude.
  typedef struct packed {
    logic              left;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] val;
  } shift_cmd_t;

  // Classify a float16 by exponent and build the shifter load command.
  function automatic shift_cmd_t f16_decode(input logic [7:0] hi, input logic [7:0] lo);
    logic [EXP_W-1:0] exp_f;
    logic [SIG_W-1:0] sig;
    shift_cmd_t       cmd;
    exp_f = hi[6:2];
    sig   = {1'b1, hi[1:0], lo};
    cmd   = '0;
    if (exp_f <= EXP_W'(EXP_ZERO_MAX)) begin
      cmd.val = '0;
    end else if (exp_f >= EXP_W'(EXP_SAT)) begin
      cmd.val = WORD_W'({MAG_W{1'b1}});
    end else if (exp_f < EXP_W'(INT_POINT)) begin
      cmd.val = WORD_W'(sig);
      cmd.cnt = CNT_W'(EXP_W'(INT_POINT) - exp_f);
    end else begin
      cmd.val  = WORD_W'(sig);
      cmd.cnt  = CNT_W'(exp_f - EXP_W'(INT_POINT));
      cmd.left = 1'b1;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/f2i_shifter.sv
// One-bit-per-cycle significand shifter with step counter.
// F2I_ROUND_EN: when defined, the bit leaving on the final right shift
// rounds the magnitude (half away from zero, saturating).
module f2i_shifter
  import f2i_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  shift_cmd_t       cmd_i,
  input  logic             shift_en_i,
  output logic [MAG_W-1:0] mag_o,
  output logic [MAG_W-1:0] next_mag_c_o,
  output logic             last_c_o
);

  logic [WORD_W-1:0] val_q, val_d, step_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              left_q, left_d;
`ifdef F2I_ROUND_EN
  logic              guard_c;
`endif

  // Next shift value, load/step selection and last-step flag.
  always_comb begin
    step_c   = left_q ? (val_q << 1) : (val_q >> 1);
    last_c_o = shift_en_i && (cnt_q == CNT_W'(1));
`ifdef F2I_ROUND_EN
    guard_c  = ~left_q & val_q[0];
    if (last_c_o && guard_c && (step_c[MAG_W-1:0] != {MAG_W{1'b1}})) begin
      step_c = step_c + WORD_W'(1);
    end
`endif
    val_d  = val_q;
    cnt_d  = cnt_q;
    left_d = left_q;
    if (load_i) begin
      val_d  = cmd_i.val;
      cnt_d  = cmd_i.cnt;
      left_d = cmd_i.left;
    end else if (shift_en_i) begin
      val_d = step_c;
      cnt_d = cnt_q - CNT_W'(1);
    end
    next_mag_c_o = val_d[MAG_W-1:0];
  end

  // Shift register, count and direction state.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q  <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
    end
  end

  assign mag_o = val_q[MAG_W-1:0];

endmodule

// File: rtl/float_to_fixed.sv
// Half-precision float in data memory -> 16-bit sign-magnitude integer.
// Optional F2I_ROUND_EN selects rounding instead of truncation (in f2i_shifter).
module float_to_fixed
  import f2i_pkg::*;
#(
  parameter int unsigned   AW       = 8,
  parameter logic [AW-1:0] SRC_ADDR = AW'(2),
  parameter logic [AW-1:0] DST_ADDR = AW'(4)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             done_q, done_d;
  logic [7:0]       lo_q, lo_d;
  logic [7:0]       hi_q, hi_d;
  logic             shift_load;
  logic             shift_en;
  logic             last_c;
  shift_cmd_t       cmd_c;
  logic [MAG_W-1:0] mag, next_mag_c;
  logic [WORD_W-1:0] res_c;

  assign cmd_c    = f16_decode(hi_q, lo_q);
  assign shift_en = (state_q == S_SHIFT);

  f2i_shifter u_shifter (
    .clk          (clk),
    .reset        (reset),
    .load_i       (shift_load),
    .cmd_i        (cmd_c),
    .shift_en_i   (shift_en),
    .mag_o        (mag),
    .next_mag_c_o (next_mag_c),
    .last_c_o     (last_c)
  );

  // Result word: settled value while writing the high byte, otherwise the value being loaded/shifted in.
  assign res_c = (state_q == S_WR_LO) ? {hi_q[7], mag} : {hi_q[7], next_mag_c};

  // Next state and registered memory/done outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = '0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    wdata_d    = '0;
    done_d     = done_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    shift_load = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RD_LO;
          addr_d  = SRC_ADDR;
          rd_d    = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_RD_LO: begin
        state_d = S_RD_HI;
        addr_d  = SRC_ADDR + AW'(1);
        rd_d    = 1'b1;
      end
      S_RD_HI: begin
        lo_d    = mem_rdata;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        hi_d    = mem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        shift_load = 1'b1;
        if (cmd_c.cnt == '0) begin
          state_d = S_WR_LO;
          addr_d  = DST_ADDR;
          wr_d    = 1'b1;
          wdata_d = res_c[7:0];
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_c) begin
          state_d = S_WR_LO;
          addr_d  = DST_ADDR;
          wr_d    = 1'b1;
          wdata_d = res_c[7:0];
        end
      end
      S_WR_LO: begin
        state_d = S_WR_HI;
        addr_d  = DST_ADDR + AW'(1);
        wr_d    = 1'b1;
        wdata_d = res_c[15:8];
      end
      S_WR_HI: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured operand and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_q;
  assign mem_wr_en = wr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// Randomized self-checking bench for float_to_fixed with a byte memory model.
module tb_float_to_fixed;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];
  int         wr_count = 0;
  logic       tb_we;
  logic [7:0] tb_addr;
  logic [7:0] tb_data;

  int n_vec = 0;
  int n_bad = 0;

  float_to_fixed dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory; junk on the read bus when not strobed.
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
    mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Value-level reference: sig * 2^(e-25), truncated or rounded, clamped.
  function automatic logic [15:0] ref_f2i(input logic [7:0] hi, input logic [7:0] lo);
    int     e;
    int     m;
    longint v;
    longint mag;
    e = int'(hi[6:2]);
    m = int'({hi[1:0], lo});
    if (e == 0) mag = 0;
    else if (e >= 30) mag = 32767;
    else begin
      v = longint'(1024 + m) << e;
`ifdef F2I_ROUND_EN
      v = v + (longint'(1) << 24);
`endif
      mag = v >>> 25;
      if (mag > 32767) mag = 32767;
    end
    return {hi[7], 15'(mag)};
  endfunction

  function automatic int ref_steps(input int e);
    if (e >= 14 && e <= 24) return 25 - e;
    if (e >= 26 && e <= 29) return e - 25;
    return 0;
  endfunction

  task automatic run_conv(input logic [7:0] hi, input logic [7:0] lo, input int restart_at);
    logic [15:0] exp_v;
    int          lat_exp;
    int          lat;
    int          w0;
    exp_v   = ref_f2i(hi, lo);
    lat_exp = 6 + ref_steps(int'(hi[6:2]));
    poke(8'd2, lo);
    poke(8'd3, hi);
    poke(8'd4, 8'hA5);
    poke(8'd5, 8'h5A);
    w0 = wr_count;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    check("done_drop", int'(done), 0);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      start = (k == restart_at);
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check("latency", lat, lat_exp);
    check("res_lo", int'(mem[4]), int'(exp_v[7:0]));
    check("res_hi", int'(mem[5]), int'(exp_v[15:8]));
    check("writes", wr_count - w0, 2);
    repeat (2) @(negedge clk);
    check("done_hold", int'(done), 1);
  endtask

  initial begin
    logic [7:0] hi, lo;
    int         w0;
    reset = 1'b1; start = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (3) @(negedge clk);
    check("rst_done", int'(done), 0);
    check("rst_wr", int'(mem_wr_en), 0);
    check("rst_rd", int'(mem_rd_en), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    reset = 1'b0;

    run_conv(8'h3C, 8'h00, 0);   // 1.0
    run_conv(8'hD6, 8'h40, 0);   // -100.0
    run_conv(8'h7C, 8'h00, 0);   // +Inf
    run_conv(8'h77, 8'hFF, 0);   // exp 29
    run_conv(8'h3A, 8'h00, 0);   // 0.75
    run_conv(8'h00, 8'h01, 0);   // denormal
    run_conv(8'h3C, 8'h00, 7);   // start pulsed during SHIFT
    run_conv(8'h64, 8'h00, 0);   // exp 25, exact
    run_conv(8'hB8, 8'h00, 0);   // -0.5, exp 14

    // Reset mid-SHIFT: no writes, outputs cleared, destination untouched.
    poke(8'd2, 8'h00);
    poke(8'd3, 8'h3C);
    poke(8'd4, 8'h5A);
    poke(8'd5, 8'hA5);
    w0 = wr_count;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_done", int'(done), 0);
    check("midrst_wr", int'(mem_wr_en), 0);
    check("midrst_rd", int'(mem_rd_en), 0);
    check("midrst_addr", int'(mem_addr), 0);
    check("midrst_wdata", int'(mem_wdata), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_lo", int'(mem[4]), 8'h5A);
    check("midrst_hi", int'(mem[5]), 8'hA5);
    check("midrst_writes", wr_count - w0, 0);
    check("midrst_idle", int'(done), 0);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        hi = 8'($urandom);
        lo = 8'($urandom);
      end else begin
        hi = {1'($urandom), 5'($urandom_range(12, 31)), 2'($urandom)};
        lo = 8'($urandom);
      end
      run_conv(hi, lo, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
